// File: rtl/zuart_pkg.sv
// zuart_pkg: shared definitions for the UART transmit arbiter.
//   - tx_state_e : arbiter FSM encoding (IDLE / SEND / GAP)
//   - CLK_HZ, BAUD_DEFAULT, TIMEOUT_DEFAULT : fabric clock and default timing
//   - idx_w()    : index width for a requester count (clog2, minimum 1)
package zuart_pkg;

    localparam int CLK_HZ          = 48_000_000;
    localparam int BAUD_DEFAULT    = 115_200;
    localparam int TIMEOUT_DEFAULT = 8192;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } tx_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/zuart_tx_arb_if.sv
// zuart_tx_arb_if: bundle of the requester and transmitter signals around
// zuart_tx_arb.
//   master : requester/transmitter side (drives valid/data/last/done)
//   slave  : arbiter side (drives ack/en/data/grant/busy/timeout)
interface zuart_tx_arb_if #(
    parameter int NReq = 4
);
    import zuart_pkg::*;
    localparam int IdxW = idx_w(NReq);

    logic [NReq-1:0]   req_valid;
    logic [8*NReq-1:0] req_data;
    logic [NReq-1:0]   req_last;
    logic [NReq-1:0]   req_ack;
    logic              tx_en;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic [IdxW-1:0]   grant_id;
    logic              busy;
    logic              timeout;

    modport master (
        output req_valid, req_data, req_last, tx_done,
        input  req_ack, tx_en, tx_data, grant_id, busy, timeout
    );

    modport slave (
        input  req_valid, req_data, req_last, tx_done,
        output req_ack, tx_en, tx_data, grant_id, busy, timeout
    );

endinterface

// File: rtl/zuart_rr_pick.sv
// zuart_rr_pick: combinational round-robin search.
//   iValid : request vector
//   iPtr   : index where the search starts (wraps NReq-1 -> 0)
//   oAny   : at least one request present
//   oIdx   : first requesting index at or after iPtr
module zuart_rr_pick #(
    parameter int NReq = 4,
    parameter int IdxW = 2
) (
    input  logic [NReq-1:0] iValid,
    input  logic [IdxW-1:0] iPtr,
    output logic            oAny,
    output logic [IdxW-1:0] oIdx
);

    int j;

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        oAny = 1'b0;
        oIdx = '0;
        j    = 0;
        for (int off = NReq - 1; off >= 0; off--) begin
            j = int'(iPtr) + off;
            if (j >= NReq) j = j - NReq;
            if (iValid[j]) begin
                oAny = 1'b1;
                oIdx = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/zuart_tx_arb.sv
// zuart_tx_arb: round-robin sequencer sharing one UART byte transmitter
// among NReq requesters. One byte per grant; waits for the transmitter's
// done pulse (or a watchdog), holds off GapCycles+1 cycles, re-arbitrates.
//
// Ports:
//   iClk, iRstN            clock, async active-low reset
//   iReqValid/Data/Last    per-requester byte offer (Last used with lock)
//   oReqAck                one-cycle one-hot pulse when a byte is latched
//   oTxEn, oTxData         transmitter enable and byte
//   iTxDone                transmitter single-cycle done pulse
//   oGrantId               index of current/last grantee
//   oBusy                  high in SEND and GAP
//   oTimeout               one-cycle pulse on watchdog abort
//
// Optional: define ZUART_TXARB_LOCK_EN to keep the grant on one requester
// until it sends a byte flagged iReqLast (or its byte times out).
module zuart_tx_arb
    import zuart_pkg::*;
#(
    parameter int NReq          = 4,
    parameter int GapCycles     = 2,
    parameter int TimeoutCycles = TIMEOUT_DEFAULT,
    localparam int IdxW         = idx_w(NReq)
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic [NReq-1:0]   iReqValid,
    input  logic [8*NReq-1:0] iReqData,
    input  logic [NReq-1:0]   iReqLast,
    output logic [NReq-1:0]   oReqAck,
    output logic              oTxEn,
    output logic [7:0]        oTxData,
    input  logic              iTxDone,
    output logic [IdxW-1:0]   oGrantId,
    output logic              oBusy,
    output logic              oTimeout
);

    localparam logic [7:0]  GAP_INIT   = 8'(GapCycles);
    localparam logic [15:0] TIMER_LAST = 16'(TimeoutCycles - 1);

    tx_state_e       state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [15:0]     timer_q, timer_d;
    logic [7:0]      gap_q, gap_d;
    logic [NReq-1:0] ack_q, ack_d;
    logic            tx_en_q, tx_en_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

    logic            grant_fire, byte_done, byte_abort;
    logic [NReq-1:0] elig;
    logic            pick_any;
    logic [IdxW-1:0] pick_idx;

    zuart_rr_pick #(.NReq(NReq), .IdxW(IdxW)) u_pick (
        .iValid (elig),
        .iPtr   (ptr_q),
        .oAny   (pick_any),
        .oIdx   (pick_idx)
    );

`ifdef ZUART_TXARB_LOCK_EN
    // Locked to grant_q while a multi-byte packet is in flight.
    logic lock_q, lock_d, last_q, last_d;

    always_comb begin
        lock_d = lock_q;
        last_d = last_q;
        if (grant_fire) begin
            last_d = iReqLast[pick_idx];
            if (!iReqLast[pick_idx]) lock_d = 1'b1;
        end
        if ((byte_done && last_q) || byte_abort) lock_d = 1'b0;
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            lock_q <= 1'b0;
            last_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
            last_q <= last_d;
        end
    end

    assign elig = lock_q ? (iReqValid & (NReq'(1) << grant_q)) : iReqValid;
`else
    logic unused_last;
    assign unused_last = ^iReqLast;
    assign elig        = iReqValid;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        ack_d      = '0;
        tx_en_d    = tx_en_q;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        timeout_d  = 1'b0;
        grant_fire = 1'b0;
        byte_done  = 1'b0;
        byte_abort = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_fire       = 1'b1;
                    tx_data_d        = iReqData[{pick_idx, 3'b000} +: 8];
                    grant_d          = pick_idx;
                    ack_d[pick_idx]  = 1'b1;
                    tx_en_d          = 1'b1;
                    ptr_d            = (pick_idx == IdxW'(NReq - 1)) ? '0 : pick_idx + IdxW'(1);
                    timer_d          = '0;
                    state_d          = ST_SEND;
                end
            end
            ST_SEND: begin
                timer_d = timer_q + 16'd1;
                // Done has priority over a watchdog expiring in the same cycle.
                if (iTxDone) begin
                    byte_done = 1'b1;
                    tx_en_d   = 1'b0;
                    gap_d     = GAP_INIT;
                    state_d   = ST_GAP;
                end else if (timer_q == TIMER_LAST) begin
                    byte_abort = 1'b1;
                    tx_en_d    = 1'b0;
                    timeout_d  = 1'b1;
                    gap_d      = GAP_INIT;
                    state_d    = ST_GAP;
                end
            end
            ST_GAP: begin
                // Counts GapCycles..0, giving GapCycles+1 cycles with oTxEn low.
                if (gap_q == 8'd0) state_d = ST_IDLE;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            timer_q   <= '0;
            gap_q     <= '0;
            ack_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            timer_q   <= timer_d;
            gap_q     <= gap_d;
            ack_q     <= ack_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign oReqAck  = ack_q;
    assign oTxEn    = tx_en_q;
    assign oTxData  = tx_data_q;
    assign oGrantId = grant_q;
    assign oBusy    = busy_q;
    assign oTimeout = timeout_q;

endmodule

// File: tb/tb_zuart_tx_arb.sv
// tb_zuart_tx_arb: self-checking bench for zuart_tx_arb.
// A timestamp-based reference model predicts every output each cycle;
// directed scenarios add literal expectations, then a randomized run
// with stray done pulses and random requesters follows.
module tb_zuart_tx_arb;
    import zuart_pkg::*;

    localparam int NREQ = 4;
    localparam int GAP  = 2;
    localparam int TMO  = 8192;
    localparam int IW   = idx_w(NREQ);

    logic iClk  = 1'b0;
    logic iRstN = 1'b0;

    zuart_tx_arb_if #(.NReq(NREQ)) bif ();

    zuart_tx_arb #(.NReq(NREQ), .GapCycles(GAP), .TimeoutCycles(TMO)) dut (
        .iClk      (iClk),
        .iRstN     (iRstN),
        .iReqValid (bif.req_valid),
        .iReqData  (bif.req_data),
        .iReqLast  (bif.req_last),
        .oReqAck   (bif.req_ack),
        .oTxEn     (bif.tx_en),
        .oTxData   (bif.tx_data),
        .iTxDone   (bif.tx_done),
        .oGrantId  (bif.grant_id),
        .oBusy     (bif.busy),
        .oTimeout  (bif.timeout)
    );

    always #5 iClk = ~iClk;

    int checks = 0;
    int fails  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model (absolute cycle timestamps) -----------
    int              cyc = 0;
    int              g_cyc = 0;      // cycle in which the current grant was made
    int              idle_from = 0;  // first cycle back in IDLE after a gap
    int              m_ptr = 0;
    int              m_grant = 0;
    logic [7:0]      m_data = '0;
    logic [NREQ-1:0] m_ack = '0;
    bit              m_txen = 0, m_busy = 0, m_to = 0;
    bit              m_lock = 0, m_last = 0;
    int              m_lock_id = 0;

    initial begin
        int k;
        bit found;
        forever begin
            @(posedge iClk or negedge iRstN);
            if (!iRstN) begin
                cyc = 0; m_ptr = 0; m_grant = 0; m_data = '0; m_ack = '0;
                m_txen = 0; m_busy = 0; m_to = 0; m_lock = 0; m_last = 0;
            end else begin
                m_ack = '0;
                m_to  = 0;
                if (m_txen) begin
                    if (bif.tx_done || (cyc - g_cyc) == TMO) begin
                        m_to      = !bif.tx_done;
                        m_txen    = 0;
                        idle_from = cyc + GAP + 2;
                        if (!bif.tx_done || m_last) m_lock = 0;
                    end
                end else if (m_busy) begin
                    if (cyc + 1 >= idle_from) m_busy = 0;
                end else begin
                    found = 0;
                    k = 0;
                    for (int off = 0; off < NREQ; off++) begin
                        if (!found && bif.req_valid[(m_ptr + off) % NREQ] &&
                            (!m_lock || ((m_ptr + off) % NREQ) == m_lock_id)) begin
                            found = 1;
                            k = (m_ptr + off) % NREQ;
                        end
                    end
                    if (found) begin
                        m_ack[k] = 1'b1;
                        m_txen   = 1;
                        m_busy   = 1;
                        m_data   = bif.req_data[8*k +: 8];
                        m_grant  = k;
                        m_ptr    = (k + 1) % NREQ;
                        g_cyc    = cyc;
                        m_last   = bif.req_last[k];
`ifdef ZUART_TXARB_LOCK_EN
                        if (!bif.req_last[k]) begin
                            m_lock    = 1;
                            m_lock_id = k;
                        end
`endif
                    end
                end
                cyc++;
            end
        end
    end

    // ---------------- per-cycle compare against the model ------------------
    initial begin
        forever begin
            @(negedge iClk);
            checks++;
            if ({bif.req_ack, bif.tx_en, bif.tx_data, bif.grant_id, bif.busy, bif.timeout} !==
                {m_ack, m_txen, m_data, IW'(m_grant), m_busy, m_to}) begin
                fails++;
                $display("FAIL cycle_compare t=%0t: got ack=%b en=%b data=%h gid=%0d busy=%b to=%b expected ack=%b en=%b data=%h gid=%0d busy=%b to=%b",
                         $time, bif.req_ack, bif.tx_en, bif.tx_data, bif.grant_id, bif.busy, bif.timeout,
                         m_ack, m_txen, m_data, m_grant, m_busy, m_to);
            end
        end
    end

    // ---------------- environment: requesters + transmitter -----------------
    int rem[NREQ];          // bytes still queued per requester
    int tx_cnt = 0;
    int tx_target = 0;      // SEND cycle in which done pulses; 0 = never
    int fixed_target = -1;  // -1: random target per byte
    bit rand_mode = 0;
    bit stray_en = 0;

    task automatic drive_req();
        for (int i = 0; i < NREQ; i++) begin
            bif.req_valid[i] = (rem[i] > 0);
            bif.req_last[i]  = (rem[i] == 1);
        end
    endtask

    task automatic env();
        if (bif.tx_en) begin
            tx_cnt++;
            if (tx_cnt == 1) tx_target = (fixed_target >= 0) ? fixed_target : int'($urandom_range(1, 40));
            bif.tx_done = (tx_cnt == tx_target);
        end else begin
            tx_cnt = 0;
            bif.tx_done = stray_en && ($urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (bif.req_ack[i] && rem[i] > 0) begin
                rem[i]--;
                bif.req_data[8*i +: 8] = 8'($urandom);
            end
            if (rand_mode && rem[i] == 0 && $urandom_range(0, 7) == 0) begin
                rem[i] = int'($urandom_range(1, 3));
                bif.req_data[8*i +: 8] = 8'($urandom);
            end
        end
        drive_req();
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
        env();
        @(negedge iClk);
    endtask

    task automatic set_req(input int i, input int n, input logic [7:0] d);
        rem[i] = n;
        bif.req_data[8*i +: 8] = d;
        drive_req();
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) rem[i] = 0;
        drive_req();
    endtask

    task automatic wait_grant(output int gid);
        gid = -1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (|bif.req_ack) begin
                gid = int'(bif.grant_id);
                break;
            end
        end
        check("grant_seen", gid >= 0, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20000 && bif.busy; k++) tick();
        check("idle_reached", bif.busy, 0);
    endtask

    task automatic rst_pulse();
        #2 iRstN = 1'b0;
        clear_reqs();
        tick();
        tick();
        #2 iRstN = 1'b1;
    endtask

    function automatic bit any_rem();
        bit r = 0;
        for (int i = 0; i < NREQ; i++) if (rem[i] != 0) r = 1;
        return r;
    endfunction

    // ---------------- directed scenarios + random run -----------------------
    initial begin
        int gid, hi, lo, to_seen;
        int got[5];
        int exp_rr[5]   = '{0, 1, 2, 3, 0};
`ifdef ZUART_TXARB_LOCK_EN
        int exp_lock[4] = '{0, 0, 0, 1};
`else
        int exp_lock[4] = '{0, 1, 0, 0};
`endif
        bif.req_valid = '0;
        bif.req_data  = '0;
        bif.req_last  = '0;
        bif.tx_done   = 1'b0;
        clear_reqs();
        tick(); tick(); tick();
        check("rst_txen",    bif.tx_en,    0);
        check("rst_busy",    bif.busy,     0);
        check("rst_ack",     bif.req_ack,  0);
        check("rst_gid",     bif.grant_id, 0);
        check("rst_txdata",  bif.tx_data,  0);
        check("rst_timeout", bif.timeout,  0);
        #2 iRstN = 1'b1;

        // single byte from requester 1, done after 4600 SEND cycles
        fixed_target = 4600;
        tick();
        set_req(1, 1, 8'h5A);
        tick();
        check("t1_ack",    bif.req_ack,  4'b0010);
        check("t1_data",   bif.tx_data,  8'h5A);
        check("t1_gid",    bif.grant_id, 1);
        hi = 0;
        while (bif.tx_en && hi < 20000) begin hi++; tick(); end
        check("t1_txen_len", hi, 4600);
        lo = 0;
        while (bif.busy && !bif.tx_en && lo < 100) begin lo++; tick(); end
        check("t1_gap_len", lo, 3);
        check("t1_idle", bif.busy, 0);

        // all requesters valid: plain round robin from 0
        rst_pulse();
        fixed_target = 5;
        set_req(0, 2, 8'h10);
        set_req(1, 1, 8'h11);
        set_req(2, 1, 8'h12);
        set_req(3, 1, 8'h13);
        for (int g = 0; g < 5; g++) begin
            wait_grant(gid);
            got[g] = gid;
            check("rr_ack_onehot", bif.req_ack, (gid >= 0) ? (1 << gid) : 0);
            tick();
            check("rr_ack_pulse", bif.req_ack, 0);
        end
        for (int g = 0; g < 5; g++) check($sformatf("rr_order%0d", g), got[g], exp_rr[g]);
        wait_idle();

        // wrap search: pointer 1 -> grant 2 -> pointer 3 -> req1 only -> grant 1
        set_req(2, 1, 8'h22);
        wait_grant(gid); check("wrap_pre", gid, 2); wait_idle();
        set_req(1, 1, 8'h21);
        wait_grant(gid); check("wrap_grant", gid, 1); wait_idle();
        set_req(1, 1, 8'h31);
        set_req(2, 1, 8'h32);
        wait_grant(gid); check("wrap_ptr2", gid, 2);
        wait_grant(gid); check("wrap_then1", gid, 1); wait_idle();

        // watchdog abort, then the next requester is served
        fixed_target = 0;
        set_req(3, 1, 8'h43);
        set_req(0, 1, 8'h40);
        wait_grant(gid); check("to_grant", gid, 3);
        fixed_target = 7;
        hi = 0; to_seen = 0;
        while (bif.tx_en && hi < 20000) begin hi++; to_seen |= int'(bif.timeout); tick(); end
        check("to_txen_len", hi, TMO);
        check("to_quiet_in_send", to_seen, 0);
        check("to_pulse", bif.timeout, 1);
        tick();
        check("to_pulse_end", bif.timeout, 0);
        wait_grant(gid); check("to_next", gid, 0); wait_idle();

        // done lands on the last watchdog cycle: no abort
        fixed_target = TMO;
        set_req(1, 1, 8'h51);
        wait_grant(gid); check("co_grant", gid, 1);
        hi = 0;
        while (bif.tx_en && hi < 20000) begin hi++; tick(); end
        check("co_txen_len", hi, TMO);
        lo = 0; to_seen = 0;
        while (bif.busy && !bif.tx_en && lo < 100) begin lo++; to_seen |= int'(bif.timeout); tick(); end
        check("co_no_timeout", to_seen, 0);
        check("co_gap_len", lo, 3);

        // reset in the middle of a byte
        fixed_target = 200;
        set_req(2, 1, 8'h62);
        wait_grant(gid); check("mr_grant", gid, 2);
        repeat (10) tick();
        check("mr_txen_before", bif.tx_en, 1);
        #2 iRstN = 1'b0;
        #1;
        check("mr_txen_async", bif.tx_en, 0);
        check("mr_busy_async", bif.busy, 0);
        clear_reqs();
        tick(); tick();
        #2 iRstN = 1'b1;
        fixed_target = 4;
        set_req(1, 1, 8'h71);
        set_req(3, 1, 8'h73);
        wait_grant(gid); check("mr_first_after", gid, 1);
        wait_grant(gid); check("mr_second_after", gid, 3); wait_idle();

        // packet of three bytes from req0 with req1 waiting
        rst_pulse();
        fixed_target = 3;
        set_req(0, 3, 8'h80);
        set_req(1, 1, 8'h81);
        for (int g = 0; g < 4; g++) begin
            wait_grant(gid);
            check($sformatf("lock_order%0d", g), gid, exp_lock[g]);
        end
        wait_idle();

        // randomized traffic with stray done pulses
        rst_pulse();
        fixed_target = -1;
        rand_mode = 1;
        stray_en = 1;
        repeat (20000) tick();
        rand_mode = 0;
        for (int k = 0; k < 5000 && (any_rem() || bif.busy); k++) tick();
        stray_en = 0;
        check("drain_done", any_rem() || bif.busy, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/zuart_tx_arb.md
Name: zuart_tx_arb

Overview:
Round-robin arbiter/sequencer that shares one UART byte transmitter among NReq byte requesters on the 48 MHz iCE40UP5K fabric clock. It accepts one byte per grant through a valid/ack handshake and drives the transmitter's enable/data inputs. It waits for the transmitter's single-cycle done pulse, inserts an inter-byte gap, then re-arbitrates. A watchdog aborts a byte whose done pulse never arrives.

Parameters:
NReq, 4, number of requesters (2..8)
GapCycles, 2, extra idle cycles after each byte before re-arbitration (0..255)
TimeoutCycles, 8192, SEND-state watchdog limit in iClk cycles (1..65535)

Ports:
iClk  in  1  system clock, 48 MHz
iRstN  in  1  reset, asynchronous, active-low
iReqValid  in  NReq  per-requester byte valid; held with data until acked
iReqData  in  8*NReq  requester i byte at [8*i+7:8*i]
iReqLast  in  NReq  last byte of packet (used only with ZUART_TXARB_LOCK_EN)
oReqAck  out  NReq  one-hot, one-cycle pulse: byte latched
oTxEn  out  1  transmitter enable, high for the whole byte
oTxData  out  8  byte to transmitter, stable while oTxEn=1
iTxDone  in  1  transmitter single-cycle done pulse
oGrantId  out  clog2(NReq)  index of current/last grantee
oBusy  out  1  high in every state except IDLE
oTimeout  out  1  one-cycle pulse on watchdog abort

Behaviour:
- Reset (async assert, sync release): state=IDLE, oReqAck=0, oTxEn=0, oTxData=0, oGrantId=0, oBusy=0, oTimeout=0, RR pointer=0, timers=0.
- All outputs registered.
- States: IDLE, SEND, GAP.
- IDLE: if any iReqValid, pick first valid index searching upward from pointer with wrap (NReq-1 -> 0). At that edge: oTxData<=iReqData[k], oGrantId<=k, oReqAck[k]<=1 (one cycle), oTxEn<=1, pointer<=(k+1) mod NReq, timer<=0, go SEND.
- No valid: remain IDLE, outputs unchanged.
- Latency: valid seen in cycle n -> oTxEn and ack high in cycle n+1.
- Requester may drop valid or change data the cycle after ack.
- SEND: timer increments each cycle.
  - iTxDone=1: oTxEn<=0, gap counter<=GapCycles, go GAP.
  - Else timer==TimeoutCycles-1: oTxEn<=0, oTimeout<=1 (one cycle), go GAP.
  - iTxDone and timeout in the same cycle: done wins, no oTimeout.
- GAP: lasts GapCycles+1 cycles, so oTxEn is low for at least 1 cycle and the transmitter returns to its idle step. Then go IDLE.
- iTxDone outside SEND is ignored.
- iReqValid toggling outside IDLE has no effect; no ack is issued.
- Reset mid-SEND: oTxEn drops immediately (async); the byte is lost; pointer returns to 0.
- oBusy=1 in SEND and GAP.

Optional Feature:
ZUART_TXARB_LOCK_EN
- Defined: a grant to k with iReqLast[k]=0 locks arbitration to k. While locked, IDLE considers only iReqValid[k]. The lock releases after a byte with iReqLast=1 completes, or on oTimeout. The pointer still advances to k+1 on each grant, so after release the search starts past k.
- Undefined: iReqLast ignored; pure per-byte round-robin.

Decomposition:
- Package zuart_pkg:
  - state encoding (IDLE/SEND/GAP)
  - CLK_HZ=48_000_000
  - default baud 115200
  - TIMEOUT_DEFAULT
  - helper constant for clog2(NReq)
- Sub-module zuart_rr_pick (combinational): iValid[NReq], iPtr -> oAny, oIdx. It holds the wrap search; instantiated once.

Test Plan:
- Single requester 1 valid with byte 0x5A; model done 4600 cycles later -> ack[1] pulse next cycle, oTxEn high 4600 cycles with oTxData=0x5A, low for exactly 3 cycles (GapCycles=2), then IDLE.
- All 4 valid continuously -> grants 0,1,2,3,0 in order; each ack pulse exactly 1 cycle; oGrantId matches.
- Pointer=3, only req 1 valid -> wrap search grants 1; pointer becomes 2.
- No done pulse -> oTxEn drops and oTimeout pulses at SEND cycle 8192; next valid requester granted after the gap.
- Done and timeout coincide at cycle 8191 -> no oTimeout, normal GAP.
- Assert iRstN low mid-SEND -> oTxEn=0 same cycle; after release the first grant starts from index 0.
- LOCK_EN: req0 sends 3 bytes (last on 3rd) with req1 valid throughout -> 0,0,0,1.
